beam_topk_sort: RTL and testbench
=================================

// Module: beam_topk_sort
// PURPOSE
//  Streaming top-K beam selector, directly upstream of the codeword-reversal stage.
//  Takes one power value per candidate beam (NBEAM per RBG) and keeps a running
//  descending-sorted list of the K strongest beams.
//  Presents their 8-bit indices as o_beam_idx, then strobes o_rbg_load so the
//  downstream stage can latch its per-beam codewords.
// PARAMETERS
//  NBEAM  64  candidate beams per RBG; NBEAM >= K, NBEAM <= 256
//  K      16  beams kept; equals BEAM of the downstream stage
//  PWR_W  32  unsigned beam-power width
// PORTS
//  i_clk          in   1          clock
//  i_reset_n      in   1          asynchronous, active-low reset
//  i_pwr_vld      in   1          power sample valid; gaps allowed, no backpressure
//  i_pwr_sop      in   1          qualifies i_pwr_vld; marks beam 0 of a new RBG
//  i_pwr          in   PWR_W      beam power, unsigned
//  o_beam_idx     out  K*8        [K-1:0][7:0]; slot 0 holds the strongest beam
//  o_beam_pwr     out  K*PWR_W    power per slot, debug only
//  o_rbg_load     out  1          1-cycle pulse; o_beam_idx is already stable
//  o_short_err    out  1          1-cycle pulse: RBG aborted by early sop
//  o_long_err     out  1          1-cycle pulse: sample dropped (no sop / RBG complete)
// BEHAVIOUR
//  Reset:
//   - o_beam_idx[k]=k (identity); o_beam_pwr=0; all pulses 0; FSM=IDLE; cnt=0.
//  FSM:
//   - IDLE -(vld&sop)-> COLLECT.
//   - COLLECT -(accepted sample with cnt==NBEAM-1)-> EMIT.
//   - EMIT -> IDLE, after one cycle.
//  Sample acceptance:
//   - vld&sop in any state: clear list valid bits, insert sample as beam 0, cnt=1.
//   - If in COLLECT with cnt!=0, also pulse o_short_err next cycle.
//   - vld&!sop in COLLECT: insert as beam idx=cnt, cnt++.
//   - vld&!sop in IDLE/EMIT: sample dropped; o_long_err pulses next cycle.
//  Insertion, one sample per cycle, list updated at the next edge:
//   - gt[k] = !valid[k] | (i_pwr > pwr[k]). Strict compare: on a tie the earlier
//     (lower-index) beam keeps the higher slot.
//   - gt is thermometer-coded. p = lowest k with gt[k].
//   - Slots <p hold. Slot p takes {i_pwr,cnt}. Slots >p take slot k-1.
//   - If no gt bit is set, the sample is discarded.
//  Output timing, with t = edge where the last sample is accepted:
//   - List is final after edge t+1.
//   - o_beam_idx/o_beam_pwr are copied from the list at edge t+2 and hold until the
//     next EMIT.
//   - o_rbg_load is high for cycle t+3 only, so the downstream registered select
//     path sees stable indices one cycle before the load.
//  Corner cases:
//   - Reset mid-RBG: list and outputs return to reset values; no o_rbg_load.
//   - sop in the same cycle as EMIT: the new RBG starts and the emit still completes,
//     because the output copy is taken from the final list snapshot.
//   - Gapped vld: insertion stalls; cnt holds.
//  Indices are 8 bits and zero-extended from cnt. Power is compared unsigned,
//  with no saturation.
// STRUCTURE
//  - Shared package pusch_dr_pkg holds the NBEAM/K defaults, typedef beam_entry_t
//    {logic vld; logic [PWR_W-1:0] pwr; logic [7:0] idx}, and the FSM state enum.
//  - Sub-module beam_sort_slot: one list slot. It owns the comparator, the gt output,
//    the mux that selects hold/insert/shift-from-upper, and the entry register.
//    Top level: K slots, counter, FSM, output copy, error pulses.
// TESTING
//  1. Powers 0..63 ascending, gap-free
//     -> o_beam_idx = {63,62,...,48} (slot0=63); o_rbg_load at t+3.
//  2. Powers 63..0 descending -> o_beam_idx = {0..15}.
//  3. All powers 100 (ties) -> o_beam_idx = {0..15}; o_beam_pwr all 100.
//  4. Beam 40=0xFFFF_FFFF, others random, vld toggling 50%
//     -> slot0=40; exactly one o_rbg_load per RBG.
//  5. sop at sample 30, then a full RBG -> o_short_err at t+1 of the 2nd sop; a single
//     o_rbg_load reflecting only the 2nd RBG.
//     A 65th sample without sop -> o_long_err; outputs unchanged.
//  6. i_reset_n low at sample 20 -> o_beam_idx = identity, no o_rbg_load;
//     next full RBG sorts correctly.

Source files
------------

// File: rtl/pusch_dr_pkg.sv
// Shared types and defaults for the PUSCH beam-selection / codeword-reversal path.
// Latency: n/a (types only).
// Backpressure: n/a.
package pusch_dr_pkg;

    localparam int NBEAM_DEF = 64;
    localparam int K_DEF     = 16;
    localparam int PWR_W_DEF = 32;

    // One entry of the running sorted beam list.
    typedef struct packed {
        logic                 vld;
        logic [PWR_W_DEF-1:0] pwr;
        logic [7:0]           idx;
    } beam_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } sort_state_t;

endpackage

// File: rtl/beam_sort_slot.sv
// One slot of the insertion-sorted beam list: comparator, hold/insert/shift mux, entry register.
// Latency: registered sample lands in the list one edge after it is presented on i_ins.
// Backpressure: none; one insertion per cycle, always accepted.
//  Ports: i_ins_* = pending sample (valid, clear-list, entry); i_upper/i_gt_upper = slot k-1
//         entry and its gt bit (tied to 0 for slot 0); o_gt = sample outranks this slot;
//         o_entry = current slot contents.
module beam_sort_slot
    import pusch_dr_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_ins_vld,
    input  logic        i_ins_clr,
    input  beam_entry_t i_ins,
    input  beam_entry_t i_upper,
    input  logic        i_gt_upper,
    output logic        o_gt,
    output beam_entry_t o_entry
);

    beam_entry_t entry_q;

    // A clearing sample outranks every slot, which forces the insert point to slot 0.
    // Strict compare keeps the earlier beam above a later beam of equal power.
    assign o_gt    = i_ins_clr | ~entry_q.vld | (i_ins.pwr > entry_q.pwr);
    assign o_entry = entry_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            entry_q <= '0;
        end else if (i_ins_vld) begin
            if (i_ins_clr) begin
                // New RBG: slot 0 takes the sample, all other slots are invalidated.
                entry_q <= i_gt_upper ? beam_entry_t'('0) : i_ins;
            end else if (o_gt) begin
                // gt is thermometer-coded: the first set slot inserts, the rest shift down.
                entry_q <= i_gt_upper ? i_upper : i_ins;
            end
        end
    end

endmodule

// File: rtl/beam_topk_sort.sv
// Streaming top-K beam selector: keeps a descending list of the K strongest beams per RBG.
// Latency: indices updated 2 edges after the last sample is accepted, o_rbg_load 1 cycle later.
// Backpressure: none; i_pwr_vld may gap, samples outside an RBG are dropped with o_long_err.
//  Ports: i_pwr_vld/i_pwr_sop/i_pwr = power stream; o_beam_idx/o_beam_pwr = sorted result
//         (slot 0 strongest); o_rbg_load = result-ready pulse; o_short_err/o_long_err = framing pulses.
module beam_topk_sort
    import pusch_dr_pkg::*;
#(
    parameter int NBEAM = NBEAM_DEF,
    parameter int K     = K_DEF,
    parameter int PWR_W = PWR_W_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_pwr_vld,
    input  logic                      i_pwr_sop,
    input  logic [PWR_W-1:0]          i_pwr,
    output logic [K-1:0][7:0]         o_beam_idx,
    output logic [K-1:0][PWR_W-1:0]   o_beam_pwr,
    output logic                      o_rbg_load,
    output logic                      o_short_err,
    output logic                      o_long_err
);

    localparam int CNT_W = 9;

    sort_state_t      state;
    logic [CNT_W-1:0] cnt;

    // Accepted sample, registered one cycle ahead of the list update.
    logic             ins_vld;
    logic             ins_clr;
    beam_entry_t      ins;

    logic             emit_d1;
    logic             copy_done;

    logic [K-1:0]     gt;
    beam_entry_t      list [K];

    for (genvar k = 0; k < K; k++) begin : g_slot
        if (k == 0) begin : g_top
            beam_sort_slot u_slot (
                .i_clk      (i_clk),
                .i_reset_n  (i_reset_n),
                .i_ins_vld  (ins_vld),
                .i_ins_clr  (ins_clr),
                .i_ins      (ins),
                .i_upper    (beam_entry_t'('0)),
                .i_gt_upper (1'b0),
                .o_gt       (gt[k]),
                .o_entry    (list[k])
            );
        end else begin : g_rest
            beam_sort_slot u_slot (
                .i_clk      (i_clk),
                .i_reset_n  (i_reset_n),
                .i_ins_vld  (ins_vld),
                .i_ins_clr  (ins_clr),
                .i_ins      (ins),
                .i_upper    (list[k-1]),
                .i_gt_upper (gt[k-1]),
                .o_gt       (gt[k]),
                .o_entry    (list[k])
            );
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ins_vld     <= 1'b0;
            ins_clr     <= 1'b0;
            ins         <= '0;
            emit_d1     <= 1'b0;
            copy_done   <= 1'b0;
            o_rbg_load  <= 1'b0;
            o_short_err <= 1'b0;
            o_long_err  <= 1'b0;
            for (int k = 0; k < K; k++) begin
                o_beam_idx[k] <= 8'(k);
                o_beam_pwr[k] <= '0;
            end
        end else begin
            ins_vld     <= 1'b0;
            ins_clr     <= 1'b0;
            o_short_err <= 1'b0;
            o_long_err  <= 1'b0;

            // Output pipeline: EMIT cycle -> list final -> copy -> load pulse.
            emit_d1    <= (state == ST_EMIT);
            copy_done  <= emit_d1;
            o_rbg_load <= copy_done;

            // The copy reads the list before any new-RBG insertion lands on the same edge.
            if (emit_d1) begin
                for (int k = 0; k < K; k++) begin
                    o_beam_idx[k] <= list[k].idx;
                    o_beam_pwr[k] <= PWR_W'(list[k].pwr);
                end
            end

            if (state == ST_EMIT) begin
                state <= ST_IDLE;
            end

            if (i_pwr_vld) begin
                if (i_pwr_sop) begin
                    o_short_err <= (state == ST_COLLECT) && (cnt != '0);
                    ins_vld     <= 1'b1;
                    ins_clr     <= 1'b1;
                    ins         <= '{vld: 1'b1, pwr: PWR_W_DEF'(i_pwr), idx: 8'd0};
                    cnt         <= CNT_W'(1);
                    state       <= (NBEAM == 1) ? ST_EMIT : ST_COLLECT;
                end else if (state == ST_COLLECT) begin
                    ins_vld <= 1'b1;
                    ins     <= '{vld: 1'b1, pwr: PWR_W_DEF'(i_pwr), idx: cnt[7:0]};
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NBEAM - 1)) begin
                        state <= ST_EMIT;
                    end
                end else begin
                    o_long_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_beam_topk_sort.sv
module tb_beam_topk_sort;

    localparam int NBEAM = 64;
    localparam int K     = 16;
    localparam int PWR_W = 32;

    logic                    i_clk;
    logic                    i_reset_n;
    logic                    i_pwr_vld;
    logic                    i_pwr_sop;
    logic [PWR_W-1:0]        i_pwr;
    logic [K-1:0][7:0]       o_beam_idx;
    logic [K-1:0][PWR_W-1:0] o_beam_pwr;
    logic                    o_rbg_load;
    logic                    o_short_err;
    logic                    o_long_err;

    beam_topk_sort #(.NBEAM(NBEAM), .K(K), .PWR_W(PWR_W)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_pwr_vld   (i_pwr_vld),
        .i_pwr_sop   (i_pwr_sop),
        .i_pwr       (i_pwr),
        .o_beam_idx  (o_beam_idx),
        .o_beam_pwr  (o_beam_pwr),
        .o_rbg_load  (o_rbg_load),
        .o_short_err (o_short_err),
        .o_long_err  (o_long_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int n_edge = 0;
    always @(posedge i_clk) n_edge++;

    logic [PWR_W-1:0]        smp [NBEAM];
    bit                      collecting = 0;
    int                      mcnt = 0;
    int                      out_edge = -1, load_edge = -1, short_edge = -1, long_edge = -1;
    logic [K-1:0][7:0]       exp_idx, pend_idx;
    logic [K-1:0][PWR_W-1:0] exp_pwr, pend_pwr;
    int                      load_cnt = 0, short_cnt = 0, long_cnt = 0;

    // Stable descending selection: equal powers keep the lower beam index first.
    task automatic model_rank();
        bit taken [NBEAM];
        for (int i = 0; i < NBEAM; i++) taken[i] = 0;
        for (int k = 0; k < K; k++) begin
            int best = -1;
            for (int i = 0; i < NBEAM; i++)
                if (!taken[i] && (best < 0 || smp[i] > smp[best])) best = i;
            taken[best] = 1;
            pend_idx[k] = 8'(best);
            pend_pwr[k] = smp[best];
        end
    endtask

    always @(negedge i_clk) begin
        if (o_rbg_load)  load_cnt++;
        if (o_short_err) short_cnt++;
        if (o_long_err)  long_cnt++;
        if (!i_reset_n) begin
            collecting = 0; mcnt = 0;
            out_edge = -1; load_edge = -1; short_edge = -1; long_edge = -1;
            for (int k = 0; k < K; k++) begin
                exp_idx[k] = 8'(k);
                exp_pwr[k] = '0;
            end
        end else if (n_edge == out_edge) begin
            exp_idx = pend_idx;
            exp_pwr = pend_pwr;
        end
        chk("beam_idx", 512'(o_beam_idx), 512'(exp_idx));
        chk("beam_pwr", 512'(o_beam_pwr), 512'(exp_pwr));
        chk("rbg_load", 512'(o_rbg_load), 512'(i_reset_n && n_edge == load_edge));
        chk("short_err", 512'(o_short_err), 512'(i_reset_n && n_edge == short_edge));
        chk("long_err", 512'(o_long_err), 512'(i_reset_n && n_edge == long_edge));
        // Inputs now stable are taken at edge n_edge+1.
        if (i_reset_n && i_pwr_vld) begin
            if (i_pwr_sop) begin
                if (collecting && mcnt != 0) short_edge = n_edge + 1;
                smp[0] = i_pwr;
                mcnt = 1;
                collecting = 1;
            end else if (collecting) begin
                smp[mcnt] = i_pwr;
                mcnt++;
                if (mcnt == NBEAM) begin
                    collecting = 0;
                    model_rank();
                    out_edge  = n_edge + 3;
                    load_edge = n_edge + 4;
                end
            end else begin
                long_edge = n_edge + 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [PWR_W-1:0] p, input bit sop);
        @(posedge i_clk); #1;
        i_pwr_vld = 1'b1; i_pwr_sop = sop; i_pwr = p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
            i_pwr_vld = 1'b0; i_pwr_sop = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int l0, s0, g0;
        logic [K-1:0][7:0] ident;
        for (int k = 0; k < K; k++) ident[k] = 8'(k);

        i_reset_n = 1'b0; i_pwr_vld = 1'b0; i_pwr_sop = 1'b0; i_pwr = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_idx", 512'(o_beam_idx), 512'(ident));
        chk("reset_load", 512'(o_rbg_load), 512'(0));
        i_reset_n = 1'b1;
        idle(2);

        // 1: ascending
        l0 = load_cnt;
        for (int i = 0; i < NBEAM; i++) send(32'(i), i == 0);
        idle(8);
        chk("t1_slot0", 512'(o_beam_idx[0]), 512'(63));
        chk("t1_slot15", 512'(o_beam_idx[15]), 512'(48));
        chk("t1_loads", 512'(load_cnt - l0), 512'(1));

        // 2: descending
        for (int i = 0; i < NBEAM; i++) send(32'(63 - i), i == 0);
        idle(8);
        chk("t2_idx", 512'(o_beam_idx), 512'(ident));

        // 3: all ties
        for (int i = 0; i < NBEAM; i++) send(32'd100, i == 0);
        idle(8);
        chk("t3_idx", 512'(o_beam_idx), 512'(ident));
        chk("t3_pwr7", 512'(o_beam_pwr[7]), 512'(100));

        // 4: one huge beam, random others, ~50% gaps
        for (int r = 0; r < 2; r++) begin
            l0 = load_cnt;
            for (int i = 0; i < NBEAM; i++) begin
                if ($urandom_range(0, 1) == 1) idle(1);
                send((i == 40) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 1000)), i == 0);
            end
            idle(8);
            chk("t4_slot0", 512'(o_beam_idx[0]), 512'(40));
            chk("t4_loads", 512'(load_cnt - l0), 512'(1));
        end

        // 5: aborted RBG, then a full RBG, then a stray 65th sample
        l0 = load_cnt; s0 = short_cnt; g0 = long_cnt;
        for (int i = 0; i < 30; i++) send(32'(1000 + i), i == 0);
        for (int i = 0; i < NBEAM; i++) send(32'((i * 37) % 64), i == 0);
        send(32'hFFFF_FFFF, 1'b0);
        idle(8);
        chk("t5_short", 512'(short_cnt - s0), 512'(1));
        chk("t5_long", 512'(long_cnt - g0), 512'(1));
        chk("t5_loads", 512'(load_cnt - l0), 512'(1));
        chk("t5_slot0", 512'(o_beam_idx[0]), 512'(19));

        // 6: reset mid-RBG
        l0 = load_cnt;
        for (int i = 0; i < 20; i++) send(32'(500 - i), i == 0);
        @(posedge i_clk); #1;
        i_pwr_vld = 1'b0; i_pwr_sop = 1'b0; i_reset_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("t6_idx", 512'(o_beam_idx), 512'(ident));
        i_reset_n = 1'b1;
        idle(6);
        chk("t6_noload", 512'(load_cnt - l0), 512'(0));
        for (int i = 0; i < NBEAM; i++) send(32'(i), i == 0);
        idle(8);
        chk("t6_slot0", 512'(o_beam_idx[0]), 512'(63));
        chk("t6_loads", 512'(load_cnt - l0), 512'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
